// File: rtl/mt_z_collector.sv
// Packs the 1-bit z result stream LSB-first into WIDTH-bit words carrying length and ones count.
// A flush emits a partial word; each word leaves on a valid/ready handshake.
module mt_z_collector #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             in_valid,
    input  logic             in_z,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic [CNT_W-1:0] out_len,
    output logic [CNT_W-1:0] out_ones,
    output logic [15:0]      word_count
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_ones;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_word;
    logic [CNT_W-1:0] r_out_len;
    logic [CNT_W-1:0] r_out_ones;
    logic [15:0]      r_word_count;

    logic             w_accept;
    logic             w_bit;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_inc;
    logic [CNT_W-1:0] w_idx_inc;
    logic [CNT_W-1:0] w_ones_inc;
    logic             w_emit;
    logic             w_release;

    assign in_ready   = (r_state == COLLECT);
    assign out_valid  = r_out_valid;
    assign out_word   = r_out_word;
    assign out_len    = r_out_len;
    assign out_ones   = r_out_ones;
    assign word_count = r_word_count;

    // Gating in_z with the accept keeps an unaccepted (possibly X) bit out of the datapath.
    assign w_accept   = in_valid && (r_state == COLLECT);
    assign w_bit      = w_accept & in_z;
    assign w_last     = w_accept && (r_idx == CNT_W'(WIDTH - 1));
    assign w_acc_inc  = r_acc | (WIDTH'(w_bit) << r_idx);
    assign w_idx_inc  = r_idx + CNT_W'(w_accept);
    assign w_ones_inc = r_ones + CNT_W'(w_bit);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            COLLECT: begin
                // A full word takes priority; flush only matters when something is held.
                w_emit = w_last || (flush && (w_idx_inc != '0));
                if (w_emit) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                w_release = out_ready;
                if (w_release) begin
                    w_state_nxt = COLLECT;
                end
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_acc        <= '0;
            r_idx        <= '0;
            r_ones       <= '0;
            r_out_valid  <= 1'b0;
            r_out_word   <= '0;
            r_out_len    <= '0;
            r_out_ones   <= '0;
            r_word_count <= '0;
        end else begin
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_word  <= w_acc_inc;
                r_out_len   <= w_idx_inc;
                r_out_ones  <= w_ones_inc;
                r_acc       <= w_acc_inc;
                r_idx       <= w_idx_inc;
                r_ones      <= w_ones_inc;
            end else if (w_accept) begin
                r_acc  <= w_acc_inc;
                r_idx  <= w_idx_inc;
                r_ones <= w_ones_inc;
            end
            if (w_release) begin
                r_out_valid  <= 1'b0;
                r_acc        <= '0;
                r_idx        <= '0;
                r_ones       <= '0;
                r_word_count <= r_word_count + 16'd1;
            end
        end
    end

endmodule
